// File: rtl/vga_pkg.sv
// VGA timing constants shared by the video pipeline.
package vga_pkg;

    localparam int H_TOTAL = 1650;

endpackage

// File: rtl/vram_pkg.sv
// Shared types and default widths for VRAM access.
package vram_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU
    } owner_t;

    typedef enum logic {
        ARB_ACTIVE,
        ARB_BLANK
    } arb_state_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating wait counter; flags when the waiter has been held off LIMIT cycles.
module arb_wait_cnt #(
    parameter int LIMIT = 1650
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic clr_i,
    output logic starve_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starve_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wait_i && cnt_q != CW'(LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= (cnt_d == CW'(LIMIT));
        end
    end

    assign starve_o = starve_q;

endmodule

// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: display owns the RAM during active video,
// blanking shares it round-robin with the CPU.
module vram_arbiter
    import vram_pkg::*;
    import vga_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = H_TOTAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hblnk,
    input  logic              vblnk,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_starve
);

    arb_state_t        state_q;
    owner_t            last_q, win_d, tag_q, tag_d;
    logic              blank_q;
    logic              disp_gnt_q, cpu_gnt_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Display always wins while active; in blanking, contention alternates.
    always_comb begin
        win_d = OWN_NONE;
        if (disp_req && cpu_req) begin
            if (state_q == ARB_BLANK && last_q != OWN_CPU) begin
                win_d = OWN_CPU;
            end else begin
                win_d = OWN_DISP;
            end
        end else if (disp_req) begin
            win_d = OWN_DISP;
        end else if (cpu_req) begin
            win_d = OWN_CPU;
        end
    end

    // Owner of the read on the RAM port this cycle; writes return nothing.
    always_comb begin
        tag_d = OWN_NONE;
        if (disp_gnt_q) begin
            tag_d = OWN_DISP;
        end else if (cpu_gnt_q && !mem_we_q) begin
            tag_d = OWN_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q     <= 1'b0;
            state_q     <= ARB_ACTIVE;
            last_q      <= OWN_DISP;
            disp_gnt_q  <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_q       <= OWN_NONE;
        end else begin
            blank_q <= hblnk | vblnk;
            unique case (state_q)
                ARB_ACTIVE: if (blank_q)  state_q <= ARB_BLANK;
                ARB_BLANK:  if (!blank_q) state_q <= ARB_ACTIVE;
                default:    state_q <= ARB_ACTIVE;
            endcase
            disp_gnt_q <= (win_d == OWN_DISP);
            cpu_gnt_q  <= (win_d == OWN_CPU);
            mem_en_q   <= (win_d != OWN_NONE);
            mem_we_q   <= (win_d == OWN_CPU) && cpu_we;
            if (win_d == OWN_DISP) begin
                mem_addr_q <= disp_addr;
            end else if (win_d == OWN_CPU) begin
                mem_addr_q  <= cpu_addr;
                mem_wdata_q <= cpu_wdata;
            end
            if (win_d != OWN_NONE) begin
                last_q <= win_d;
            end
            tag_q <= tag_d;
        end
    end

    arb_wait_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .wait_i  (cpu_req && !cpu_gnt_q),
        .clr_i   (cpu_gnt_q),
        .starve_o(cpu_starve)
    );

    assign disp_gnt    = disp_gnt_q;
    assign cpu_gnt     = cpu_gnt_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = (tag_q == OWN_DISP);
    assign cpu_rvalid  = (tag_q == OWN_CPU);
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
    assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, VRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 1650 (one horizontal total), CPU wait cycles before cpu_starve asserts.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: hblnk, vblnk  in  1 each  blanking flags from the VGA timing generator.
REQ-007 SHALL have ports: disp_req  in  1; disp_addr  in  ADDR_W; disp_gnt  out  1; disp_rdata  out  DATA_W; disp_rvalid  out  1; display fetch port, read-only.
REQ-008 SHALL have ports: cpu_req  in  1; cpu_we  in  1; cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W; cpu_gnt  out  1; cpu_rdata  out  DATA_W; cpu_rvalid  out  1; game-logic port.
REQ-009 SHALL have ports: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; single-port RAM with 1-cycle read latency.
REQ-010 SHALL have port cpu_starve  out  1  CPU waited at least STARVE_LIMIT cycles.

Function
REQ-011 SHALL sample requests at edge T and drive registered mem_* plus a one-cycle gnt pulse to the winner during cycle T+1.
REQ-012 SHALL return read data on <owner>_rdata with <owner>_rvalid high during cycle T+2; a CPU write SHALL produce no rvalid.
REQ-013 SHALL require each requester to hold req, addr, we and wdata stable until its gnt; req held high continuously SHALL give one access per cycle.
REQ-014 SHALL register blank = hblnk | vblnk each cycle; the registered value selects the policy.
REQ-015 SHALL run FSM ACTIVE (blank=0): disp_req wins; cpu_req granted only when disp_req=0.
REQ-016 SHALL run FSM BLANK (blank=1): if one requester, grant it; if both, round-robin against last_owner, starting with CPU on the first contention after reset.
REQ-017 SHALL move ACTIVE->BLANK on registered blank rising and BLANK->ACTIVE on its falling; an access issued in the transition cycle SHALL complete normally.
REQ-018 SHALL drive mem_en=0, mem_we=0 and hold mem_addr/mem_wdata in cycles without a grant.
REQ-019 SHALL track the read owner in a one-stage tag pipeline so rvalid routes to the requester granted two cycles earlier, including back-to-back alternating owners.
REQ-020 SHALL count cycles with cpu_req=1 and cpu_gnt=0 in a counter saturating at STARVE_LIMIT, cleared on cpu_gnt; cpu_starve = (count == STARVE_LIMIT), registered.
REQ-021 SHALL NOT let cpu_starve alter arbitration; it is a status flag only.
REQ-022 SHALL never assert disp_gnt and cpu_gnt in the same cycle.

Reset
REQ-023 SHALL, on rst_n=0, immediately clear: FSM to ACTIVE, last_owner to DISP, mem_en, mem_we, mem_addr, mem_wdata, both gnt, both rvalid, both rdata, starvation counter, cpu_starve.
REQ-024 SHALL discard any in-flight read on reset; no rvalid SHALL appear for it after release.
REQ-025 SHALL accept first requests at the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL define owner_t enum {OWN_NONE, OWN_DISP, OWN_CPU} and arb_state_t enum {ARB_ACTIVE, ARB_BLANK} in a shared package vram_pkg, with ADDR_W/DATA_W defaults as localparams there.
REQ-027 SHALL take STARVE_LIMIT default from vga_pkg horizontal total.
REQ-028 SHALL place the saturating starvation counter in one sub-module arb_wait_cnt; everything else SHALL be inline.

Verification
REQ-029 Active region, disp_req and cpu_req both high for 4 cycles, with disp addr 0x010..0x013 -> 4 disp_gnt pulses, no cpu_gnt, disp_rvalid 2 cycles after each grant with RAM contents.
REQ-030 Blank region, both requesting continuously after reset -> grants alternate CPU, DISP, CPU, DISP.
REQ-031 CPU write addr 0x123 data 0x5A in blank, then CPU read 0x123 -> mem_we=1 for the write, no rvalid for it, cpu_rdata=0x5A at T+2 of the read.
REQ-032 Active region, cpu_req held with disp_req held for 1650 cycles -> cpu_starve=1 at cycle 1651; it clears the cycle after cpu_gnt, once blank allows a CPU grant.
REQ-033 Alternating DISP read/CPU read back-to-back -> each rvalid on the correct port with correct data, never both.
REQ-034 rst_n pulsed low with a read in flight -> all outputs 0 immediately, no rvalid after release, first post-reset request granted at T+1.
